// File: rtl/data_mem_stage.sv
// MEM-stage data memory: big-endian byte/half/word loads and stores with a fixed
// multi-cycle latency, pipeline stall while busy, and registered load data for WB.
module data_mem_stage #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    input  logic [1:0]            mem_size,
    input  logic                  mem_se,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned
);

    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_rw, r_se;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_aligned, w_accept, w_exec;
    logic [ADDR_WIDTH-1:0] w_a1, w_a2, w_a3;
    logic [7:0]            w_b0, w_b1, w_b2, w_b3;
    logic [31:0]           w_load;

    always_comb begin
        case (mem_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~address[0];
            2'b10:   w_aligned = (address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && mem_enable && w_aligned;
    assign w_exec   = (r_state == S_BUSY) && (r_cnt == CW'(LATENCY - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_exec)   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign stall = w_accept || (r_state == S_BUSY);
    assign done  = (r_state == S_DONE);

    // Byte lanes in big-endian order: b0 is the most significant byte.
    assign w_a1 = r_addr + ADDR_WIDTH'(1);
    assign w_a2 = r_addr + ADDR_WIDTH'(2);
    assign w_a3 = r_addr + ADDR_WIDTH'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_se & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{r_se & w_b0[7]}}, w_b0, w_b1};
            default: w_load = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_se       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            data_out   <= '0;
            misaligned <= 1'b0;
        end else begin
            r_state    <= w_next;
            misaligned <= (r_state == S_IDLE) && mem_enable && !w_aligned;
            if (w_accept) begin
                r_cnt   <= '0;
                r_rw    <= mem_rw;
                r_se    <= mem_se;
                r_size  <= mem_size;
                r_addr  <= address;
                r_wdata <= data_in;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_exec && !r_rw)
                data_out <= w_load;
        end
    end

    // Storage has no reset; an aborted access never reaches w_exec, so nothing is written.
    always_ff @(posedge clk) begin
        if (w_exec && r_rw) begin
            case (r_size)
                2'b00: r_mem[r_addr] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[r_addr] <= r_wdata[15:8];
                    r_mem[w_a1]   <= r_wdata[7:0];
                end
                default: begin
                    r_mem[r_addr] <= r_wdata[31:24];
                    r_mem[w_a1]   <= r_wdata[23:16];
                    r_mem[w_a2]   <= r_wdata[15:8];
                    r_mem[w_a3]   <= r_wdata[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed scoreboard bench for data_mem_stage: load results are queued when a
// request is driven and compared when done pulses.
module tb_data_mem_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_enable, mem_rw, mem_se;
    logic [1:0]  mem_size;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        stall, done, misaligned;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_q[$];
    logic [31:0] old;

    data_mem_stage #(.ADDR_WIDTH(9), .DEPTH(512), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_enable(mem_enable), .mem_rw(mem_rw),
        .mem_size(mem_size), .mem_se(mem_se), .address(address), .data_in(data_in),
        .data_out(data_out), .stall(stall), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned request in the current cycle and follows it to done.
    task automatic access(input logic rw, input logic [1:0] sz, input logic se,
                          input logic [8:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input bit hold);
        int cyc;
        bit got;
        mem_enable = 1'b1; mem_rw = rw; mem_size = sz; mem_se = se;
        address = a; data_in = d;
        if (!rw) exp_q.push_back(exp);
        #1;
        chk("stall_accept", {31'b0, stall}, 32'd1);
        chk("done_idle", {31'b0, done}, 32'd0);
        tick();
        if (!hold) begin
            // Operands are latched at accept; scrambling them must not matter.
            mem_enable = 1'b0; mem_rw = ~rw; mem_size = ~sz; mem_se = ~se;
            address = ~a; data_in = ~d;
        end
        cyc = 1;
        got = 1'b0;
        while (cyc <= 12 && !got) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                chk("stall_busy", {31'b0, stall}, 32'd1);
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, LAT + 1);
            chk("stall_done", {31'b0, stall}, 32'd0);
            if (!rw) begin
                if (exp_q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
                else chk("load_data", data_out, exp_q.pop_front());
            end
        end
        tick();
    endtask

    task automatic reject(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] keep);
        mem_enable = 1'b1; mem_rw = 1'b0; mem_size = sz; mem_se = 1'b0;
        address = a; data_in = 32'h0;
        #1;
        chk("rej_stall", {31'b0, stall}, 32'd0);
        tick();
        mem_enable = 1'b0;
        @(negedge clk);
        chk("rej_misaligned", {31'b0, misaligned}, 32'd1);
        chk("rej_stall_next", {31'b0, stall}, 32'd0);
        chk("rej_data_hold", data_out, keep);
        tick();
        @(negedge clk);
        chk("rej_pulse_end", {31'b0, misaligned}, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b0; mem_enable = 1'b0; mem_rw = 1'b0; mem_size = 2'b00;
        mem_se = 1'b0; address = '0; data_in = '0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Word store then byte/half/word loads in big-endian order
        access(1, 2'b10, 0, 9'h004, 32'hDEADBEEF, 32'h0, 0);
        access(0, 2'b10, 0, 9'h004, 32'h0, 32'hDEADBEEF, 0);
        access(0, 2'b00, 1, 9'h005, 32'h0, 32'hFFFFFFAD, 0);
        access(0, 2'b00, 0, 9'h005, 32'h0, 32'h000000AD, 0);
        access(0, 2'b01, 1, 9'h006, 32'h0, 32'hFFFFBEEF, 0);
        access(0, 2'b01, 0, 9'h006, 32'h0, 32'h0000BEEF, 0);
        access(0, 2'b10, 1, 9'h004, 32'h0, 32'hDEADBEEF, 0);

        // Half store uses the low two bytes of data_in
        access(1, 2'b10, 0, 9'h008, 32'h00000000, 32'h0, 0);
        access(1, 2'b01, 0, 9'h008, 32'hFFFF5678, 32'h0, 0);
        access(0, 2'b10, 0, 9'h008, 32'h0, 32'h56780000, 0);

        // Byte store at the top of memory
        access(1, 2'b10, 0, 9'h1FC, 32'h01020304, 32'h0, 0);
        access(1, 2'b00, 0, 9'h1FF, 32'hAABBCC12, 32'h0, 0);
        access(0, 2'b10, 0, 9'h1FC, 32'h0, 32'h01020312, 0);
        access(0, 2'b00, 1, 9'h1FF, 32'h0, 32'h00000012, 0);

        // Rejected requests
        old = 32'h00000012;
        reject(2'b10, 9'h006, old);
        reject(2'b11, 9'h000, old);
        reject(2'b01, 9'h007, old);
        reject(2'b10, 9'h1FE, old);

        // Reset in the first BUSY cycle discards the pending store
        access(1, 2'b10, 0, 9'h010, 32'hCAFEF00D, 32'h0, 0);
        access(0, 2'b10, 0, 9'h010, 32'h0, 32'hCAFEF00D, 0);
        mem_enable = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_se = 1'b0;
        address = 9'h010; data_in = 32'h11223344;
        tick();
        mem_enable = 1'b0;
        reset = 1'b0;
        #2;
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_data", data_out, 32'd0);
        reset = 1'b1;
        tick();
        chk("abort_idle_stall", {31'b0, stall}, 32'd0);
        tick(); tick(); tick();
        chk("abort_no_done", {31'b0, done}, 32'd0);
        access(0, 2'b10, 0, 9'h010, 32'h0, 32'hCAFEF00D, 0);

        // mem_enable held across DONE; next load accepted right after DONE
        access(0, 2'b10, 0, 9'h004, 32'h0, 32'hDEADBEEF, 1);
        access(0, 2'b01, 1, 9'h010, 32'h0, 32'hFFFFCAFE, 0);
        @(negedge clk);
        chk("idle_done_low", {31'b0, done}, 32'd0);
        chk("idle_stall_low", {31'b0, stall}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
